// File: rtl/light_sequencer_pkg.sv
// Shared phase and light definitions for light_sequencer and its consumer scp_079.
// Phase codes, counter width and the one-hot light vector layout live here.
package light_sequencer_pkg;

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CNT_MAX = 63;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2,
    PH_RED    = 2'd3
  } phase_e;

  // Bit order is {green, yellow, red}.
  typedef logic [2:0] light_t;

  localparam light_t LIGHT_OFF    = 3'b000;
  localparam light_t LIGHT_GREEN  = 3'b100;
  localparam light_t LIGHT_YELLOW = 3'b010;
  localparam light_t LIGHT_RED    = 3'b001;

  function automatic light_t light_of(input phase_e ph);
    light_t l;
    case (ph)
      PH_GREEN:  l = LIGHT_GREEN;
      PH_YELLOW: l = LIGHT_YELLOW;
      PH_RED:    l = LIGHT_RED;
      default:   l = LIGHT_OFF;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/light_sequencer_phase_timer.sv
// Loadable down-counter for phase timing: load wins over hold, and it stops at zero.
// The zero flag tells the sequencer that the current phase is on its last cycle.
module phase_timer
  import light_sequencer_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             hold_i,
  output logic [CNT_W-1:0] count_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (!hold_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/light_sequencer.sv
// GREEN -> YELLOW -> RED light sequencer with enable, alarm and hold overrides.
// Drives the one-hot light inputs of scp_079; all outputs are registered.
module light_sequencer
  import light_sequencer_pkg::*;
#(
  parameter int unsigned GREEN_CYC  = 40,
  parameter int unsigned YELLOW_CYC = 5,
  parameter int unsigned RED_CYC    = 18
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             hold,
  input  logic             alarm,
  output logic             green,
  output logic             yellow,
  output logic             red,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] remaining,
  output logic             cycle_done
);

  if ((GREEN_CYC < 1) || (GREEN_CYC > CNT_MAX) ||
      (YELLOW_CYC < 1) || (YELLOW_CYC > CNT_MAX) ||
      (RED_CYC < 1) || (RED_CYC > CNT_MAX)) begin : g_bad_dur
    $error("light_sequencer: phase durations must be in 1..63");
  end

  localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] RED_M1    = CNT_W'(RED_CYC - 1);

  phase_e           state_q, state_d;
  light_t           light_q, light_d;
  logic             done_q, done_d;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] count;
  logic             zero;

  phase_timer u_timer (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (load),
    .load_val_i (load_val),
    .hold_i     (hold),
    .count_o    (count),
    .zero_o     (zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PH_IDLE;
      light_q <= LIGHT_OFF;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      light_q <= light_d;
      done_q  <= done_d;
    end
  end

  // Override priority: enable low, then alarm, then hold, then normal counting.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    if (!enable) begin
      state_d = PH_IDLE;
      load    = 1'b1;
    end else if (alarm) begin
      if (state_q != PH_IDLE) begin
        state_d  = PH_RED;
        load     = 1'b1;
        load_val = RED_M1;
      end
    end else if (!hold) begin
      case (state_q)
        PH_IDLE: begin
          state_d  = PH_GREEN;
          load     = 1'b1;
          load_val = GREEN_M1;
        end
        PH_GREEN: if (zero) begin
          state_d  = PH_YELLOW;
          load     = 1'b1;
          load_val = YELLOW_M1;
        end
        PH_YELLOW: if (zero) begin
          state_d  = PH_RED;
          load     = 1'b1;
          load_val = RED_M1;
        end
        PH_RED: if (zero) begin
          state_d  = PH_GREEN;
          load     = 1'b1;
          load_val = GREEN_M1;
        end
        default: state_d = PH_IDLE;
      endcase
    end
  end

  // Alarm entry into RED never produces a RED->GREEN step, so it cannot pulse done.
  always_comb begin
    light_d = light_of(state_d);
    done_d  = (state_q == PH_RED) && (state_d == PH_GREEN);
  end

  assign green      = light_q[2];
  assign yellow     = light_q[1];
  assign red        = light_q[0];
  assign phase      = state_q;
  assign remaining  = count;
  assign cycle_done = done_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: a default-duration and a 1/1/1 instance share stimulus
// and are checked every cycle against a phase/elapsed-time model plus directed literals.
module tb_light_sequencer;

  logic clock;
  logic reset_n;
  logic enable;
  logic hold;
  logic alarm;

  logic       g   [2];
  logic       y   [2];
  logic       r   [2];
  logic [1:0] ph  [2];
  logic [5:0] rem [2];
  logic       cd  [2];

  int checks = 0;
  int errors = 0;

  light_sequencer dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .hold(hold), .alarm(alarm),
    .green(g[0]), .yellow(y[0]), .red(r[0]), .phase(ph[0]),
    .remaining(rem[0]), .cycle_done(cd[0])
  );

  light_sequencer #(.GREEN_CYC(1), .YELLOW_CYC(1), .RED_CYC(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .hold(hold), .alarm(alarm),
    .green(g[1]), .yellow(y[1]), .red(r[1]), .phase(ph[1]),
    .remaining(rem[1]), .cycle_done(cd[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase number 0..3 plus cycles already spent in that phase.
  int mph  [2] = '{0, 0};
  int mel  [2] = '{0, 0};
  int mdone[2] = '{0, 0};

  function automatic int dur(input int k, input int p);
    if (k == 1) return 1;
    case (p)
      1:       return 40;
      2:       return 5;
      default: return 18;
    endcase
  endfunction

  function automatic int mlights(input int p);
    case (p)
      1:       return 4;
      2:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        mph[k] <= 0; mel[k] <= 0; mdone[k] <= 0;
      end else if (!enable) begin
        mph[k] <= 0; mel[k] <= 0; mdone[k] <= 0;
      end else if (alarm) begin
        if (mph[k] != 0) begin
          mph[k] <= 3; mel[k] <= 0;
        end
        mdone[k] <= 0;
      end else if (hold) begin
        mdone[k] <= 0;
      end else if (mph[k] == 0) begin
        mph[k] <= 1; mel[k] <= 0; mdone[k] <= 0;
      end else if (mel[k] == dur(k, mph[k]) - 1) begin
        mdone[k] <= (mph[k] == 3) ? 1 : 0;
        mph[k]   <= (mph[k] == 3) ? 1 : mph[k] + 1;
        mel[k]   <= 0;
      end else begin
        mel[k]   <= mel[k] + 1;
        mdone[k] <= 0;
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      chk(k == 0 ? "d0_lights" : "d1_lights", int'({g[k], y[k], r[k]}), mlights(mph[k]));
      chk(k == 0 ? "d0_phase" : "d1_phase", int'(ph[k]), mph[k]);
      chk(k == 0 ? "d0_remaining" : "d1_remaining", int'(rem[k]),
          (mph[k] == 0) ? 0 : dur(k, mph[k]) - 1 - mel[k]);
      chk(k == 0 ? "d0_cycle_done" : "d1_cycle_done", int'(cd[k]), mdone[k]);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clock);
  endtask

  int gc, yc, rc, dc, gc1, dc1, n;

  initial begin
    reset_n = 1'b0; enable = 1'b0; hold = 1'b0; alarm = 1'b0;
    repeat (2) step();
    chk("rst_phase", int'(ph[0]), 0);
    chk("rst_lights", int'({g[0], y[0], r[0]}), 0);
    chk("rst_remaining", int'(rem[0]), 0);
    reset_n = 1'b1;
    step();
    chk("idle_wo_enable", int'(ph[0]), 0);

    // Full default rotation
    enable = 1'b1;
    step();
    chk("start_green", int'({g[0], y[0], r[0]}), 4);
    chk("start_rem", int'(rem[0]), 39);
    gc = 0; yc = 0; rc = 0; dc = 0; gc1 = 0; dc1 = 0;
    for (int c = 0; c < 63; c++) begin
      gc += int'(g[0]); yc += int'(y[0]); rc += int'(r[0]); dc += int'(cd[0]);
      gc1 += int'(g[1]); dc1 += int'(cd[1]);
      step();
    end
    chk("green_cycles", gc, 40);
    chk("yellow_cycles", yc, 5);
    chk("red_cycles", rc, 18);
    chk("done_before_63", dc, 0);
    chk("d1_green_cycles", gc1, 21);
    chk("d1_done_pulses", dc1, 20);
    chk("done_at_63", int'(cd[0]), 1);
    chk("wrap_rem", int'(rem[0]), 39);

    // Hold at remaining 20
    repeat (19) step();
    chk("pre_hold_rem", int'(rem[0]), 20);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_rem", int'(rem[0]), 20);
      chk("hold_green", int'(g[0]), 1);
    end
    hold = 1'b0;
    step();
    chk("post_hold_rem", int'(rem[0]), 19);

    // Alarm at remaining 30 for 4 cycles
    enable = 1'b0;
    step();
    chk("disable_phase", int'(ph[0]), 0);
    chk("disable_rem", int'(rem[0]), 0);
    enable = 1'b1;
    step();
    repeat (9) step();
    chk("pre_alarm_rem", int'(rem[0]), 30);
    alarm = 1'b1;
    step();
    chk("alarm_red", int'({g[0], y[0], r[0]}), 1);
    chk("alarm_rem", int'(rem[0]), 17);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("alarm_hold_rem", int'(rem[0]), 17);
    end
    alarm = 1'b0;
    n = 0;
    while (r[0] && n < 40) begin
      n++;
      step();
    end
    chk("red_after_alarm", n, 18);
    chk("done_after_alarm_red", int'(cd[0]), 1);

    // Alarm and hold together in YELLOW, then enable low with alarm
    repeat (40) step();
    chk("yellow_entry", int'({g[0], y[0], r[0]}), 2);
    chk("yellow_rem", int'(rem[0]), 4);
    alarm = 1'b1; hold = 1'b1;
    step();
    chk("alarm_beats_hold", int'({g[0], y[0], r[0]}), 1);
    chk("alarm_beats_hold_rem", int'(rem[0]), 17);
    enable = 1'b0;
    step();
    chk("enable_beats_alarm", int'({g[0], y[0], r[0]}), 0);
    chk("enable_beats_alarm_ph", int'(ph[0]), 0);
    alarm = 1'b0; hold = 1'b0; enable = 1'b1;
    step();
    chk("restart_rem", int'(rem[0]), 39);

    // Asynchronous reset mid-YELLOW
    repeat (41) step();
    chk("mid_yellow_rem", int'(rem[0]), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_lights", int'({g[0], y[0], r[0]}), 0);
    chk("async_phase", int'(ph[0]), 0);
    chk("async_rem", int'(rem[0]), 0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_reset_green", int'(g[0]), 1);
    chk("post_reset_rem", int'(rem[0]), 39);
    repeat (3) step();
    chk("d1_three_cycle_done", int'(cd[1]), 1);
    chk("d1_three_cycle_green", int'(g[1]), 1);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Drives the one-hot `green`/`yellow`/`red` light inputs of the `scp_079` controller. It steps through GREEN → YELLOW → RED phases with parameterised durations, and supports hold, enable and alarm overrides. It sits upstream of `scp_079` in the final-project top level and replaces hand-written light stimulus.

## Interface
- `GREEN_CYC`, default 40: cycles spent in GREEN; legal range 1..63.
- `YELLOW_CYC`, default 5: cycles spent in YELLOW; legal range 1..63.
- `RED_CYC`, default 18: cycles spent in RED; legal range 1..63.
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: run the sequence; low returns the block to IDLE.
- `hold`  in  1: freeze the current phase and count.
- `alarm`  in  1: force RED while high; intended to be driven from `scp_079.cheat_out`.
- `green`  out  1: light output, registered.
- `yellow`  out  1: light output, registered.
- `red`  out  1: light output, registered.
- `phase`  out  2: 0 = IDLE, 1 = GREEN, 2 = YELLOW, 3 = RED.
- `remaining`  out  6: cycles left in the current phase, minus one.
- `cycle_done`  out  1: one-cycle pulse on the RED → GREEN transition.

## Operation
- States are IDLE, GREEN, YELLOW and RED. Each state maps one-hot onto `green`/`yellow`/`red`; in IDLE all three are 0.
- Reset value of every output is 0, which places the block in IDLE.
- IDLE → GREEN when `enable`=1 and `alarm`=0.
- Entering a phase loads `remaining` with DUR-1 for that phase.
- Each cycle in a phase, with no override active:
  - if `remaining`≠0, decrement it;
  - if `remaining`=0, advance: GREEN → YELLOW → RED → GREEN.
- Each phase therefore lasts exactly DUR cycles.
- RED → GREEN asserts `cycle_done` for 1 cycle, aligned with the first GREEN cycle.
- Override priority, highest first: `enable`=0 > `alarm` > `hold` > normal counting.
  - `enable`=0: next state is IDLE and `remaining`=0, from any state, including mid-phase.
  - `alarm`=1 (with `enable`=1): from GREEN or YELLOW, go to RED at the next edge and load RED_CYC-1. While `alarm` stays high in RED, `remaining` stays at RED_CYC-1. Counting resumes the cycle after `alarm` falls, giving a full RED_CYC of red. From IDLE, `alarm`=1 blocks the start.
  - `hold`=1: `remaining` and state are frozen, including when `remaining`=0.
- Alarm-forced entry into RED is not a RED → GREEN wrap and does not pulse `cycle_done`.
- `remaining` is 6-bit unsigned and never wraps below 0.
- Illegal parameter values (0 or >63) are rejected by an elaboration-time check.

## Timing
- All outputs are registered and change only on the rising edge of `clock`, except on reset.
- Asserting `reset_n`=0 clears all outputs immediately. Deassertion is taken synchronously: the first transition out of IDLE happens on the first edge where `reset_n`=1 and `enable`=1.
- Latency from `enable` rising (with `reset_n`=1) to `green`=1 is 1 cycle.
- Latency from `alarm` rising to `red`=1 is 1 cycle.
- Latency from `hold` rising to the frozen count is 1 cycle: the count is unchanged at the next edge.
- With no overrides, the full sequence period is GREEN_CYC + YELLOW_CYC + RED_CYC cycles; 63 cycles at defaults.
- Exactly one of `green`/`yellow`/`red` is high outside IDLE. All three are low in IDLE.

## Structure
- Shared package holds:
  - the phase encoding constants (IDLE/GREEN/YELLOW/RED = 0..3);
  - the counter width constant (6);
  - `light_t`, the 3-bit light vector typedef.
- `scp_079` consumes the same phase/light constants.
- The block has one sub-module, `phase_timer`: a loadable 6-bit down-counter with `load`, `load_val`, `hold` and a `zero` flag.
- The FSM and override priority logic live in `light_sequencer`.

## Test plan
- Default parameters, `enable`=1 after reset → `green` high for 40 cycles, `yellow` for 5, `red` for 18, then `green` again. `cycle_done` pulses once at cycle 63.
- `hold`=1 for 10 cycles while `remaining`=20 in GREEN → `remaining` stays 20 and `green` stays high. GREEN ends 10 cycles late.
- `alarm`=1 at `remaining`=30 in GREEN, held for 4 cycles → `red`=1 the next cycle with `remaining`=17 held. After `alarm` falls, `red` lasts 18 more cycles. `cycle_done` pulses only at the following RED → GREEN.
- `alarm` and `hold` both high in YELLOW → the block goes to RED (alarm wins). `enable`=0 together with `alarm` → IDLE, all lights 0.
- `reset_n` pulled low mid-YELLOW → all outputs are 0 immediately, without waiting for a clock edge. After release with `enable`=1 → GREEN on the first edge, `remaining`=39.
- GREEN_CYC=1, YELLOW_CYC=1, RED_CYC=1 → a 3-cycle rotation, with `cycle_done` pulsing every 3 cycles.
